// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver:
// FSM state encoding, parity mode, majority vote and clog2.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    typedef enum logic {
        PAR_ODD  = 1'b0,
        PAR_EVEN = 1'b1
    } par_mode_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, oversample tick counter and 3-sample majority vote.
// bit_stb marks the resolution tick of each bit; bit_val is valid with it.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic os_tick,
    input  logic clr,
    output logic rx_s,
    output logic bit_val,
    output logic bit_stb
);

    localparam int unsigned   CW     = clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_A    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_B    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_C    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_WRAP = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   samp_a_q, samp_a_d;
    logic                   samp_b_q, samp_b_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
        cnt_d    = cnt_q;
        samp_a_d = samp_a_q;
        samp_b_d = samp_b_q;
        if (clr) begin
            cnt_d = '0;
        end else if (os_tick) begin
            cnt_d = (cnt_q == T_WRAP) ? '0 : cnt_q + 1'b1;
            if (cnt_q == T_A) samp_a_d = rx_s;
            if (cnt_q == T_B) samp_b_d = rx_s;
        end
    end

    // Third vote is taken live on the resolution tick itself.
    assign bit_stb = os_tick && !clr && (cnt_q == T_C);
    assign bit_val = maj3(samp_a_q, samp_b_q, rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            samp_a_q <= samp_a_d;
            samp_b_q <= samp_b_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: frame FSM, shift register,
// parity/framing/break detection and valid/ready holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 os_tick,
    input  logic                 pen,
    input  logic                 peven,
    input  logic                 stop2,
    output logic                 busy,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 perr,
    output logic                 ferr,
    output logic                 overrun,
    output logic                 brk
);

    localparam int unsigned   CW       = clog2(OVERSAMPLE);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] HI_LAST  = CW'(OVERSAMPLE - 1);

    rx_state_e            state_q, state_d;
    logic                 rx_s, bit_val, bit_stb, clr;
    logic                 is_break, stop_last, frame_done, exp_xor;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 pen_q, pen_d, peven_q, peven_d, stop2_q, stop2_d;
    logic                 par_bit_q, par_bit_d, par_err_q, par_err_d;
    logic                 ferr_int_q, ferr_int_d, stop_idx_q, stop_idx_d;
    logic [CW-1:0]        hi_cnt_q, hi_cnt_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 overrun_q, overrun_d, brk_q, brk_d;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .os_tick(os_tick),
        .clr    (clr),
        .rx_s   (rx_s),
        .bit_val(bit_val),
        .bit_stb(bit_stb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (!rx_s) state_d = START;
            START:    if (bit_stb) state_d = bit_val ? IDLE : DATA;
            DATA:     if (bit_stb && bit_cnt_q == LAST_BIT) state_d = pen_q ? PARITY : STOP;
            PARITY:   if (bit_stb) state_d = STOP;
            STOP: begin
                if (bit_stb) begin
                    if (is_break)       state_d = BRK_WAIT;
                    else if (stop_last) state_d = IDLE;
                end
            end
            BRK_WAIT: if (os_tick && rx_s && hi_cnt_q == HI_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        clr        = (state_q == IDLE) && !rx_s;
        stop_last  = stop_idx_q || !stop2_q;
        // Break is judged on stop bit 1 only; a second stop bit is never awaited.
        is_break   = !stop_idx_q && (shift_q == '0) && (!pen_q || !par_bit_q) && !bit_val;
        frame_done = (state_q == STOP) && bit_stb && !is_break && stop_last;
        exp_xor    = (par_mode_e'(peven_q) == PAR_EVEN) ? 1'b0 : 1'b1;
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pen_d        = pen_q;
        peven_d      = peven_q;
        stop2_d      = stop2_q;
        par_bit_d    = par_bit_q;
        par_err_d    = par_err_q;
        ferr_int_d   = ferr_int_q;
        stop_idx_d   = stop_idx_q;
        hi_cnt_d     = hi_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        overrun_d    = 1'b0;
        brk_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    pen_d      = pen;
                    peven_d    = peven;
                    stop2_d    = stop2;
                    bit_cnt_d  = '0;
                    par_bit_d  = 1'b0;
                    par_err_d  = 1'b0;
                    ferr_int_d = 1'b0;
                    stop_idx_d = 1'b0;
                end
            end
            DATA: begin
                if (bit_stb) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_stb) begin
                    par_bit_d = bit_val;
                    par_err_d = ((^shift_q) ^ bit_val) != exp_xor;
                end
            end
            STOP: begin
                if (bit_stb) begin
                    ferr_int_d = ferr_int_q | ~bit_val;
                    stop_idx_d = 1'b1;
                    hi_cnt_d   = '0;
                    brk_d      = is_break;
                end
            end
            BRK_WAIT: begin
                if (!rx_s)        hi_cnt_d = '0;
                else if (os_tick) hi_cnt_d = hi_cnt_q + 1'b1;
            end
            default: ;
        endcase

        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        if (frame_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_q;
                perr_d       = par_err_q;
                ferr_d       = ferr_int_q | ~bit_val;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pen_q        <= 1'b0;
            peven_q      <= 1'b0;
            stop2_q      <= 1'b0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            ferr_int_q   <= 1'b0;
            stop_idx_q   <= 1'b0;
            hi_cnt_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pen_q        <= pen_d;
            peven_q      <= peven_d;
            stop2_q      <= stop2_d;
            par_bit_q    <= par_bit_d;
            par_err_q    <= par_err_d;
            ferr_int_q   <= ferr_int_d;
            stop_idx_q   <= stop_idx_d;
            hi_cnt_q     <= hi_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            overrun_q    <= overrun_d;
            brk_q        <= brk_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign perr       = perr_q;
    assign ferr       = ferr_q;
    assign overrun    = overrun_q;
    assign brk        = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are built from data/parity/stop
// rules, expected words queued at frame start, a monitor checks on each accept.
module tb_uart_rx_param;

    localparam int unsigned DB       = 8;
    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned GAP      = 32;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b0, rx = 1'b1, os_tick = 1'b0;
    logic          pen = 1'b0, peven = 1'b0, stop2 = 1'b0, dout_ready = 1'b0;
    logic          busy, dout_valid, perr, ferr, overrun, brk;
    logic [DB-1:0] dout;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int unsigned   n_checks = 0, n_fail = 0;
    int unsigned   tick_cnt = 0, frame_t0 = 0;
    int unsigned   overrun_seen = 0, overrun_exp = 0, brk_seen = 0, brk_exp = 0;
    logic          model_full = 1'b0;
    logic          prev_hold = 1'b0, prev_acc = 1'b0, prev_ovr = 1'b0, prev_brk = 1'b0;
    logic [DB+1:0] prev_word = '0;
    event          ev_frame_start;

    uart_rx_param #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .os_tick   (os_tick),
        .pen       (pen),
        .peven     (peven),
        .stop2     (stop2),
        .busy      (busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .perr      (perr),
        .ferr      (ferr),
        .overrun   (overrun),
        .brk       (brk)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    always @(posedge clk) if (os_tick) tick_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compares the held word on every accept, plus hold stability and pulse widths.
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
            prev_ovr  = 1'b0;
            prev_brk  = 1'b0;
        end else begin
            if (prev_acc && dout_ready) check("valid_drops_after_accept", dout_valid, 0);
            if (prev_hold && dout_valid) check("hold_stable", {dout, perr, ferr}, prev_word);
            if (dout_valid && dout_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("dout", dout, mon_e.data);
                    check("perr", perr, mon_e.perr);
                    check("ferr", ferr, mon_e.ferr);
                end
            end
            if (prev_ovr) check("overrun_width", overrun, 0);
            if (prev_brk) check("brk_width", brk, 0);
            if (overrun) overrun_seen++;
            if (brk) brk_seen++;
            prev_acc  = dout_valid && dout_ready;
            prev_hold = dout_valid && !dout_ready;
            prev_word = {dout, perr, ferr};
            prev_ovr  = overrun;
            prev_brk  = brk;
        end
    end

    task automatic hold_until(input int unsigned t);
        while (tick_cnt < t) @(negedge clk);
    endtask

    task automatic align_tick(output int unsigned t0);
        @(posedge clk iff os_tick);
        @(negedge clk);
        t0 = tick_cnt;
    endtask

    task automatic send_frame(input logic [DB-1:0] data, input logic p_en, input logic p_even,
                              input logic s2, input logic par_flip, input logic stop1_v,
                              input logic stop2_v, input int glitch_bit, input logic coincide,
                              input logic scramble);
        int unsigned t0, ones;
        logic        pbit, brk_frame;
        logic        bits[$];
        exp_t        e;
        ones      = $countones(data);
        pbit      = (p_even ? (ones % 2 == 1) : (ones % 2 == 0)) ^ par_flip;
        brk_frame = (data == 0) && (!p_en || !pbit) && !stop1_v;
        if (brk_frame) begin
            brk_exp++;
        end else if (model_full && !coincide) begin
            overrun_exp++;
        end else begin
            e.data = data;
            e.perr = p_en && par_flip;
            e.ferr = !stop1_v || (s2 && !stop2_v);
            exp_q.push_back(e);
            model_full = !dout_ready;
        end
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DB); i++) bits.push_back(data[i]);
        if (p_en) bits.push_back(pbit);
        bits.push_back(stop1_v);
        if (s2) bits.push_back(stop2_v);
        pen = p_en; peven = p_even; stop2 = s2;
        align_tick(t0);
        frame_t0 = t0;
        ->ev_frame_start;
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            if (i > 0) check("busy_in_frame", busy, 1);
            if (i == 1 && scramble) begin
                pen = 1'($urandom); peven = 1'($urandom); stop2 = 1'($urandom);
            end
            if (i == glitch_bit) begin
                hold_until(t0 + OS * i + OS / 2);
                rx = ~bits[i];
                hold_until(t0 + OS * i + OS / 2 + 1);
                rx = bits[i];
            end
            hold_until(t0 + OS * (i + 1));
        end
        rx = 1'b1;
        hold_until(t0 + OS * bits.size() + GAP);
    endtask

    initial begin
        int unsigned t;
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_perr", perr, 0);
        check("rst_ferr", ferr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_brk", brk, 0);
        rst = 1'b1;
        dout_ready = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1, parity cases, stop-bit framing errors
        send_frame(8'hA5, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h03, 1, 1, 0, 1, 1, 1, -1, 0, 0);
        send_frame(8'h03, 1, 1, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h03, 1, 0, 0, 1, 1, 1, -1, 0, 0);
        send_frame(8'h03, 1, 0, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h55, 0, 0, 1, 0, 1, 0, -1, 0, 0);
        send_frame(8'h55, 0, 0, 0, 0, 0, 1, -1, 0, 0);

        // Start-bit glitch, then single-tick glitches inside data bits
        align_tick(t);
        rx = 1'b0;
        hold_until(t + 4);
        rx = 1'b1;
        check("glitch_busy_rise", busy, 1);
        hold_until(t + 24);
        check("glitch_busy_clear", busy, 0);
        send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 3, 0, 0);
        send_frame(8'h5A, 1, 1, 0, 0, 1, 1, 8, 0, 0);

        // Overrun with the holding register full
        @(posedge clk); #1 dout_ready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        check("overrun_hold_dout", dout, 8'h11);
        check("overrun_hold_valid", dout_valid, 1);
        check("overrun_count", overrun_seen, overrun_exp);
        @(posedge clk); #1 dout_ready = 1'b1;
        @(posedge clk); #1 dout_ready = 1'b0;
        model_full = 1'b0;
        check("valid_clear_after_accept", dout_valid, 0);

        // Completion in the same clk as the accept of the held word
        send_frame(8'h33, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        fork
            send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1, 1, 0);
            begin
                @(ev_frame_start);
                wait (tick_cnt >= frame_t0 + 1 + OS * (DB + 1) + OS / 2);
                repeat (3) @(posedge clk);
                #1 dout_ready = 1'b1;
                @(posedge clk);
                #1 dout_ready = 1'b0;
            end
        join
        check("coincide_no_overrun", overrun_seen, overrun_exp);
        check("coincide_dout", dout, 8'h22);
        check("coincide_valid", dout_valid, 1);
        @(posedge clk); #1 dout_ready = 1'b1;
        model_full = 1'b0;

        // Randomised frames with config inputs disturbed mid-frame
        for (int n = 0; n < 14; n++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom % 4) != 0, ($urandom % 4) != 0, -1, 0, 1);
        end

        // Break: rx low for two frame times
        align_tick(t);
        rx = 1'b0;
        hold_until(t + 20 * OS);
        brk_exp++;
        check("brk_busy_low", busy, 1);
        check("brk_count", brk_seen, brk_exp);
        rx = 1'b1;
        hold_until(t + 20 * OS + OS / 2);
        check("brk_busy_half_bit", busy, 1);
        hold_until(t + 21 * OS + 4);
        check("brk_busy_clear", busy, 0);

        // Asynchronous reset in the middle of DATA with a word held
        @(posedge clk); #1 dout_ready = 1'b0;
        send_frame(8'h5A, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        align_tick(t);
        rx = 1'b0;
        hold_until(t + 3 * OS);
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_perr", perr, 0);
        check("arst_ferr", ferr, 0);
        exp_q.delete();
        model_full = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        dout_ready = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hC3, 1, 0, 1, 0, 1, 1, -1, 0, 0);

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("overrun_total", overrun_seen, overrun_exp);
        check("brk_total", brk_seen, brk_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
